// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one read per fetch request,
// buffers the returned word and strobes it into the instruction register.
// PC redirects that arrive while a read is outstanding are held and applied
// when the fetch completes.
//
// state | meaning
// IDLE  | waiting for fetch_req; redirects apply immediately
// REQ   | read outstanding at pc; redirects are held as pending
// DONE  | one-cycle ir_load; pending or fresh redirect applied on exit
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic                 pc_update,
    input  logic [31:0]          next_pc,
    output logic                 imem_read,
    output logic [31:0]          imem_address,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_resp,
    output logic                 ir_load,
    output logic [31:0]          ir_data,
    output logic [31:0]          pc,
    output logic                 fetch_busy,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            ir_data_q, ir_data_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [31:0]            pend_pc_q, pend_pc_d;
    logic                   imem_read_q, imem_read_d;
    logic                   ir_load_q, ir_load_d;
    logic                   misaligned_q, misaligned_d;
    logic                   apply;
    logic [31:0]            target;

    // Next-state, redirect arbitration and registered-output computation.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_data_d    = ir_data_q;
        count_d      = count_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        apply        = 1'b0;
        target       = next_pc;

        case (state_q)
            IDLE: begin
                if (pc_update) begin
                    apply = 1'b1;
                end
                if (fetch_req) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // Address must stay stable, so the redirect waits; latest wins.
                if (pc_update) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = next_pc;
                end
                if (imem_resp) begin
                    ir_data_d = imem_rdata;
                    state_d   = DONE;
                end
            end
            DONE: begin
                count_d      = count_q + CNT_WIDTH'(1);
                state_d      = IDLE;
                pend_valid_d = 1'b0;
                // A fresh redirect in DONE overrides anything held from REQ.
                if (pc_update) begin
                    apply = 1'b1;
                end else if (pend_valid_q) begin
                    apply  = 1'b1;
                    target = pend_pc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (apply) begin
            pc_d = {target[31:2], 2'b00};
        end
        misaligned_d = apply && (target[1:0] != 2'b00);
        imem_read_d  = (state_d == REQ);
        ir_load_d    = (state_d == DONE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ir_data_q    <= 32'h0;
            count_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
            imem_read_q  <= 1'b0;
            ir_load_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_data_q    <= ir_data_d;
            count_q      <= count_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            imem_read_q  <= imem_read_d;
            ir_load_q    <= ir_load_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem_read    = imem_read_q;
    assign imem_address = pc_q;
    assign ir_load      = ir_load_q;
    assign ir_data      = ir_data_q;
    assign pc           = pc_q;
    assign fetch_busy   = (state_q != IDLE);
    assign misaligned   = misaligned_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance with a 2-bit counter
// shares all inputs to exercise counter wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic        pc_update = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_resp = 1'b0;

    logic        imem_read, ir_load, fetch_busy, misaligned;
    logic [31:0] imem_address, ir_data, pc, fetch_count;

    logic        imem_read2, ir_load2, fetch_busy2, misaligned2;
    logic [31:0] imem_address2, ir_data2, pc2;
    logic [1:0]  fetch_count2;

    int checks = 0;
    int errors = 0;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_update(pc_update),
        .next_pc(next_pc), .imem_read(imem_read), .imem_address(imem_address),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .ir_load(ir_load),
        .ir_data(ir_data), .pc(pc), .fetch_busy(fetch_busy),
        .misaligned(misaligned), .fetch_count(fetch_count)
    );

    fetch_unit #(.CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_update(pc_update),
        .next_pc(next_pc), .imem_read(imem_read2), .imem_address(imem_address2),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .ir_load(ir_load2),
        .ir_data(ir_data2), .pc(pc2), .fetch_busy(fetch_busy2),
        .misaligned(misaligned2), .fetch_count(fetch_count2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_read", 32'(imem_read), 32'd0);
        chk("rst_ir_load", 32'(ir_load), 32'd0);
        chk("rst_ir_data", ir_data, 32'h0);
        chk("rst_pc", pc, 32'h60);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);

        // Basic fetch, response three cycles after the request edge
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("t1_read_c0", 32'(imem_read), 32'd1);
        chk("t1_addr_c0", imem_address, 32'h60);
        chk("t1_busy_c0", 32'(fetch_busy), 32'd1);
        chk("t1_ir_load_c0", 32'(ir_load), 32'd0);
        step();
        chk("t1_read_c1", 32'(imem_read), 32'd1);
        chk("t1_addr_c1", imem_address, 32'h60);
        chk("t1_ir_load_c1", 32'(ir_load), 32'd0);
        step();
        chk("t1_addr_c2", imem_address, 32'h60);
        imem_resp  = 1'b1;
        imem_rdata = 32'h00A0_0093;
        step();
        imem_resp = 1'b0;
        chk("t1_done_ir_load", 32'(ir_load), 32'd1);
        chk("t1_done_read", 32'(imem_read), 32'd0);
        chk("t1_done_ir_data", ir_data, 32'h00A0_0093);
        chk("t1_done_busy", 32'(fetch_busy), 32'd1);
        step();
        chk("t1_idle_ir_load", 32'(ir_load), 32'd0);
        chk("t1_idle_busy", 32'(fetch_busy), 32'd0);
        chk("t1_count", fetch_count, 32'd1);
        chk("t1_ir_data_hold", ir_data, 32'h00A0_0093);

        // Redirect and fetch in the same IDLE cycle
        pc_update = 1'b1;
        next_pc   = 32'h0000_0100;
        fetch_req = 1'b1;
        step();
        pc_update = 1'b0;
        fetch_req = 1'b0;
        chk("t2_addr", imem_address, 32'h100);
        chk("t2_read", 32'(imem_read), 32'd1);
        chk("t2_misaligned", 32'(misaligned), 32'd0);
        imem_resp  = 1'b1;
        imem_rdata = 32'h1111_1111;
        step();
        imem_resp = 1'b0;
        chk("t2_ir_data", ir_data, 32'h1111_1111);
        step();
        chk("t2_count", fetch_count, 32'd2);

        // Redirects during REQ are deferred; latest one wins
        pc_update = 1'b1;
        next_pc   = 32'h60;
        step();
        pc_update = 1'b0;
        chk("t3_pc_setup", pc, 32'h60);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        pc_update = 1'b1;
        next_pc   = 32'h200;
        step();
        chk("t3_addr_after_200", imem_address, 32'h60);
        chk("t3_pc_after_200", pc, 32'h60);
        next_pc = 32'h300;
        step();
        pc_update = 1'b0;
        chk("t3_addr_after_300", imem_address, 32'h60);
        step();
        chk("t3_addr_wait", imem_address, 32'h60);
        imem_resp  = 1'b1;
        imem_rdata = 32'h2222_2222;
        step();
        imem_resp = 1'b0;
        chk("t3_done_ir_load", 32'(ir_load), 32'd1);
        chk("t3_pc_in_done", pc, 32'h60);
        step();
        chk("t3_pc_after_done", pc, 32'h300);
        chk("t3_misaligned", 32'(misaligned), 32'd0);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("t3_next_addr", imem_address, 32'h300);
        imem_resp  = 1'b1;
        imem_rdata = 32'h3333_3333;
        step();
        imem_resp = 1'b0;
        step();
        chk("t3_count", fetch_count, 32'd4);

        // Misaligned redirect in IDLE
        pc_update = 1'b1;
        next_pc   = 32'h0000_0106;
        step();
        pc_update = 1'b0;
        chk("t4_pc", pc, 32'h104);
        chk("t4_misaligned_hi", 32'(misaligned), 32'd1);
        step();
        chk("t4_misaligned_lo", 32'(misaligned), 32'd0);

        // Reset during REQ, late response afterwards
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("t5_read_before_rst", 32'(imem_read), 32'd1);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        imem_resp  = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        chk("t5_read", 32'(imem_read), 32'd0);
        chk("t5_pc", pc, 32'h60);
        chk("t5_ir_data", ir_data, 32'h0);
        chk("t5_count", fetch_count, 32'd0);
        step();
        imem_resp = 1'b0;
        chk("t5_late_ir_load", 32'(ir_load), 32'd0);
        chk("t5_late_ir_data", ir_data, 32'h0);
        chk("t5_late_busy", 32'(fetch_busy), 32'd0);

        // Back-to-back fetches with 1-cycle memory latency
        fetch_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_req_read", 32'(imem_read), 32'd1);
            imem_resp  = 1'b1;
            imem_rdata = 32'h1000 + 32'(i);
            step();
            imem_resp = 1'b0;
            chk("t6_done_ir_load", 32'(ir_load), 32'd1);
            chk("t6_done_ir_data", ir_data, 32'h1000 + 32'(i));
            step();
            chk("t6_idle_busy", 32'(fetch_busy), 32'd0);
        end
        fetch_req = 1'b0;
        chk("t6_count", fetch_count, 32'd5);
        chk("t6_count_wrap", 32'(fetch_count2), 32'd1);
        step();
        chk("t6_stays_idle", 32'(fetch_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
